collapsing_issue_queue: RTL

//  Parametrised, age-ordered, collapsing issue queue between dispatch and execute.

---
 rtl/collapsing_issue_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/collapsing_issue_queue.sv
// Age-ordered collapsing issue queue: 2-wide enqueue at the tail, 2 arbitrary removals,
// survivors compacted toward slot 0. Optional synchronous flush port under `IQ_FLUSH_EN`.
module collapsing_issue_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int IDXW  = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
`ifdef IQ_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic [1:0]             in_valid,
    input  logic [WIDTH-1:0]       in_data0,
    input  logic [WIDTH-1:0]       in_data1,
    output logic [1:0]             in_ready,
    input  logic                   out_en0,
    input  logic [IDXW-1:0]        out_idx0,
    input  logic                   out_en1,
    input  logic [IDXW-1:0]        out_idx1,
    output logic [WIDTH-1:0]       out_data0,
    output logic [WIDTH-1:0]       out_data1,
    output logic [DEPTH-1:0]       q_valid,
    output logic [DEPTH*WIDTH-1:0] q_data,
    output logic [IDXW:0]          count
);

    localparam logic [IDXW:0] FULL_C     = (IDXW+1)'(DEPTH);
    localparam logic [IDXW:0] ONE_FREE_C = (IDXW+1)'(DEPTH-1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDXW:0]    count_q, count_d;

    logic             acc0, acc1, rem0, rem1;
    logic [IDXW:0]    n_rem, n_acc, base;
    logic [WIDTH-1:0] first_data;
    logic [IDXW:0]    slot, shift, dest;
    logic             removed;

    // Handshake: lane k enqueues iff in_valid[k] & in_ready[k]; in_ready depends only on
    // the registered count, so a same-cycle removal never frees space for an enqueue.
    assign in_ready = {count_q < ONE_FREE_C, count_q < FULL_C};
    assign acc0     = in_valid[0] & in_ready[0];
    assign acc1     = in_valid[1] & in_ready[1];

    // A duplicate index is folded into a single removal by masking lane 1.
    assign rem0 = out_en0 && ({1'b0, out_idx0} < count_q);
    assign rem1 = out_en1 && ({1'b0, out_idx1} < count_q) && !(rem0 && (out_idx0 == out_idx1));

    assign n_rem      = {{IDXW{1'b0}}, rem0} + {{IDXW{1'b0}}, rem1};
    assign n_acc      = {{IDXW{1'b0}}, acc0} + {{IDXW{1'b0}}, acc1};
    assign base       = count_q - n_rem;
    assign first_data = acc0 ? in_data0 : in_data1;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = '0;
        end
        valid_d = '0;
        count_d = base + n_acc;
        slot    = '0;
        shift   = '0;
        dest    = '0;
        removed = 1'b0;

        // Each survivor slides down by the number of removals below it.
        for (int i = 0; i < DEPTH; i++) begin
            slot    = (IDXW+1)'(i);
            removed = (rem0 && ({1'b0, out_idx0} == slot)) || (rem1 && ({1'b0, out_idx1} == slot));
            shift   = {{IDXW{1'b0}}, rem0 && ({1'b0, out_idx0} < slot)}
                    + {{IDXW{1'b0}}, rem1 && ({1'b0, out_idx1} < slot)};
            dest    = slot - shift;
            if ((slot < count_q) && !removed) begin
                data_d[dest[IDXW-1:0]] = data_q[i];
            end
        end

        if (n_acc != '0) begin
            data_d[base[IDXW-1:0]] = first_data;
        end
        if (acc0 && acc1) begin
            dest                   = base + 1'b1;
            data_d[dest[IDXW-1:0]] = in_data1;
        end

`ifdef IQ_FLUSH_EN
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            count_d = '0;
        end
`endif

        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = ((IDXW+1)'(i) < count_d);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data0 = ({1'b0, out_idx0} < FULL_C) ? data_q[out_idx0] : '0;
    assign out_data1 = ({1'b0, out_idx1} < FULL_C) ? data_q[out_idx1] : '0;
    assign q_valid   = valid_q;
    assign count     = count_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign q_data[g*WIDTH +: WIDTH] = data_q[g];
    end

endmodule
